branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 27 ++
 rtl/branch_predictor_sat_counter2.sv | 25 ++
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
// Holds the 2-bit counter encoding, the default entry layout and a saturating 8-bit increment.
package branch_predictor_pkg;

    localparam int unsigned PSIZE_DEF = 5;
    localparam int unsigned BSIZE_DEF = 3;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    // Entry layout at the default sizes; the top re-declares it against its own parameters
    typedef struct packed {
        logic                           valid;
        logic [PSIZE_DEF-BSIZE_DEF-1:0] tag;
        logic [PSIZE_DEF-1:0]           target;
        ctr_t                           ctr;
    } btb_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Saturating 2-bit up/down counter step, purely combinational.
// Counts up on inc_i, down otherwise, clamping at ST and SNT.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    ctr_t cur;
    ctr_t nxt;

    always_comb begin
        cur = ctr_t'(ctr_i);
        nxt = cur;
        if (inc_i) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
        ctr_o = nxt;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, EX-stage update,
// mispredict/recover generation and saturating branch/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned Psize = PSIZE_DEF,
    parameter int unsigned Bsize = BSIZE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Psize-1:0] pc,
    output logic             take_branch,
    output logic [Psize-1:0] predicted_target,
    input  logic             upd_valid,
    input  logic [Psize-1:0] upd_pc,
    input  logic             upd_taken,
    input  logic [Psize-1:0] upd_target,
    input  logic             upd_pred_taken,
    input  logic [Psize-1:0] upd_pred_target,
    output logic             mispredict,
    output logic [Psize-1:0] recover_pc,
    output logic [7:0]       br_count,
    output logic [7:0]       mp_count
);

    localparam int unsigned NENT = 1 << Bsize;
    localparam int unsigned TW   = Psize - Bsize;

    typedef struct packed {
        logic             valid;
        logic [TW-1:0]    tag;
        logic [Psize-1:0] target;
        ctr_t             ctr;
    } entry_t;

    entry_t btb_q [NENT];
    entry_t btb_d [NENT];
    logic [7:0] br_count_q, br_count_d;
    logic [7:0] mp_count_q, mp_count_d;

    logic [Bsize-1:0] lu_idx, up_idx;
    logic [TW-1:0]    lu_tag, up_tag;
    entry_t           lu_ent, up_ent;
    logic             lu_hit, up_hit;
    logic [1:0]       ctr_next;

    assign lu_idx = pc[Bsize-1:0];
    assign lu_tag = pc[Psize-1:Bsize];
    assign up_idx = upd_pc[Bsize-1:0];
    assign up_tag = upd_pc[Psize-1:Bsize];
    assign lu_ent = btb_q[lu_idx];
    assign up_ent = btb_q[up_idx];
    assign lu_hit = lu_ent.valid && (lu_ent.tag == lu_tag);
    assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

    // Lookup reads registered state only, so a same-index update shows up next cycle
    assign take_branch      = lu_hit && lu_ent.ctr[1];
    assign predicted_target = lu_hit ? lu_ent.target : pc + Psize'(1);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign recover_pc = upd_taken ? upd_target : upd_pc + Psize'(1);

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

    sat_counter2 u_ctr (
        .ctr_i (up_ent.ctr),
        .inc_i (upd_taken),
        .ctr_o (ctr_next)
    );

    always_comb begin
        btb_d      = btb_q;
        br_count_d = br_count_q;
        mp_count_d = mp_count_q;
        if (upd_valid) begin
            br_count_d = sat_inc8(br_count_q);
            if (mispredict) mp_count_d = sat_inc8(mp_count_q);
            if (up_hit) begin
                btb_d[up_idx].ctr = ctr_t'(ctr_next);
                if (upd_taken) btb_d[up_idx].target = upd_target;
            end else if (upd_taken) begin
                btb_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: WT};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_q      <= '{default: '0};
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            btb_q      <= btb_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor: vectors are applied on the
// falling edge and outputs compared before the next rising edge.
module tb_branch_predictor;

    localparam int P = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [P-1:0] pc;
    logic         take_branch;
    logic [P-1:0] predicted_target;
    logic         upd_valid;
    logic [P-1:0] upd_pc;
    logic         upd_taken;
    logic [P-1:0] upd_target;
    logic         upd_pred_taken;
    logic [P-1:0] upd_pred_target;
    logic         mispredict;
    logic [P-1:0] recover_pc;
    logic [7:0]   br_count;
    logic [7:0]   mp_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_predictor #(.Psize(5), .Bsize(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .take_branch      (take_branch),
        .predicted_target (predicted_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .recover_pc       (recover_pc),
        .br_count         (br_count),
        .mp_count         (mp_count)
    );

    typedef struct {
        logic         rst;
        logic [P-1:0] pc;
        logic         uv;
        logic [P-1:0] upc;
        logic         ut;
        logic [P-1:0] utg;
        logic         upt;
        logic [P-1:0] uptg;
        logic         e_take;
        logic [P-1:0] e_tgt;
        logic         e_mp;
        logic [P-1:0] e_rec;
        logic [7:0]   e_br;
        logic [7:0]   e_mpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rst, input int pc_v, input int uv, input int upc,
                                input int ut, input int utg, input int upt, input int uptg,
                                input int e_take, input int e_tgt, input int e_mp,
                                input int e_rec, input int e_br, input int e_mpc);
        vec_t v;
        v.rst = rst[0];      v.pc = pc_v[P-1:0];  v.uv = uv[0];       v.upc = upc[P-1:0];
        v.ut = ut[0];        v.utg = utg[P-1:0];  v.upt = upt[0];     v.uptg = uptg[P-1:0];
        v.e_take = e_take[0]; v.e_tgt = e_tgt[P-1:0]; v.e_mp = e_mp[0];
        v.e_rec = e_rec[P-1:0]; v.e_br = e_br[7:0]; v.e_mpc = e_mpc[7:0];
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [P-1:0] p, input logic uv,
                         input logic [P-1:0] upc, input logic ut, input logic [P-1:0] utg,
                         input logic upt, input logic [P-1:0] uptg);
        @(negedge clk);
        reset = rst; pc = p; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
        #1;
    endtask

    initial begin
        reset = 1'b1; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        repeat (2) @(negedge clk);

        // Post-reset sweep: every pc misses and falls through to pc+1
        for (int p = 0; p < 32; p++) begin
            drive(1'b0, P'(p), 1'b0, '0, 1'b0, '0, 1'b0, '0);
            check($sformatf("sweep_take pc=%0d", p), take_branch, 0);
            check($sformatf("sweep_tgt pc=%0d", p), predicted_target, (p + 1) % 32);
        end
        check("reset_br_count", br_count, 0);
        check("reset_mp_count", mp_count, 0);
        check("idle_mispredict", mispredict, 0);

        //            rst pc uv upc ut utg upt uptg  take tgt mp rec br mp
        tbl.push_back(mk(0, 5, 1, 5, 1, 20, 0, 6,    0, 6,  1, 20, 0, 0)); // allocate pc5
        tbl.push_back(mk(0, 5, 0, 0, 0, 0,  0, 0,    1, 20, 0, 1,  1, 1));
        tbl.push_back(mk(0, 5, 1, 5, 0, 0,  1, 20,   1, 20, 1, 6,  1, 1)); // 2->1
        tbl.push_back(mk(0, 5, 1, 5, 0, 0,  0, 6,    0, 20, 0, 6,  2, 2)); // 1->0
        tbl.push_back(mk(0, 5, 1, 5, 0, 0,  0, 6,    0, 20, 0, 6,  3, 2)); // stays 0
        tbl.push_back(mk(0, 5, 0, 0, 0, 0,  0, 0,    0, 20, 0, 1,  4, 2));
        tbl.push_back(mk(0, 5, 1, 5, 1, 20, 0, 6,    0, 20, 1, 20, 4, 2)); // 0->1
        tbl.push_back(mk(0, 5, 0, 0, 0, 0,  0, 0,    0, 20, 0, 1,  5, 3));
        tbl.push_back(mk(0, 13, 1, 13, 1, 2, 0, 14,  0, 14, 1, 2,  5, 3)); // alias replaces 5
        tbl.push_back(mk(0, 5, 0, 0, 0, 0,  0, 0,    0, 6,  0, 1,  6, 4));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0,    1, 2,  0, 1,  6, 4));
        tbl.push_back(mk(0, 7, 1, 7, 1, 9,  1, 9,    0, 8,  0, 9,  6, 4)); // same-cycle alloc
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,  0, 0,    1, 9,  0, 1,  7, 4));
        tbl.push_back(mk(0, 31, 1, 31, 0, 0, 1, 3,   0, 0,  1, 0,  7, 4)); // wrap, miss+NT
        tbl.push_back(mk(0, 7, 0, 0, 0, 0,  0, 0,    1, 9,  0, 1,  8, 5));
        tbl.push_back(mk(0, 13, 1, 13, 1, 4, 1, 2,   1, 2,  1, 4,  8, 5)); // target mismatch
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0,    1, 4,  0, 1,  9, 6));
        tbl.push_back(mk(1, 13, 1, 3, 1, 10, 0, 4,   1, 4,  1, 10, 9, 6)); // reset wins
        tbl.push_back(mk(0, 3, 0, 0, 0, 0,  0, 0,    0, 4,  0, 1,  0, 0));
        tbl.push_back(mk(0, 13, 0, 0, 0, 0, 0, 0,    0, 14, 0, 1,  0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ut,
                  tbl[i].utg, tbl[i].upt, tbl[i].uptg);
            check($sformatf("v%0d_take", i), take_branch, tbl[i].e_take);
            check($sformatf("v%0d_tgt", i), predicted_target, tbl[i].e_tgt);
            check($sformatf("v%0d_mispredict", i), mispredict, tbl[i].e_mp);
            check($sformatf("v%0d_recover", i), recover_pc, tbl[i].e_rec);
            check($sformatf("v%0d_br_count", i), br_count, tbl[i].e_br);
            check($sformatf("v%0d_mp_count", i), mp_count, tbl[i].e_mpc);
        end

        // 300 mispredicting updates: both counters must clamp at 255
        for (int k = 0; k < 300; k++) begin
            drive(1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 5'd2);
            if (k == 254 || k == 255 || k == 256 || k == 299) begin
                check($sformatf("sat_br k=%0d", k), br_count, (k > 255) ? 255 : k);
                check($sformatf("sat_mp k=%0d", k), mp_count, (k > 255) ? 255 : k);
            end
        end
        drive(1'b0, 5'd1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        check("sat_br_final", br_count, 255);
        check("sat_mp_final", mp_count, 255);
        check("sat_entry_take", take_branch, 1);
        check("sat_entry_tgt", predicted_target, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
